instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Front end of the pipeline that produces the instruction stream consumed by `instruction_decoder`. It holds the PC and issues word reads to a synchronous instruction memory. Returned words are buffered in a small prefetch queue and presented to decode with a valid/ready handshake. A redirect input from branch/jump resolution reloads the PC and discards all younger work.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded at reset.
- `QDEPTH`, default 2: prefetch queue entries; must be ≥2 for one-per-cycle throughput.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; state clears immediately on assertion; release is synchronous to `clk`.
- `imem_rd_en`  out  1  read request this cycle.
- `imem_addr`  out  32  word-aligned read address; bits [1:0] are always 0.
- `imem_rd_data`  in  32  read data, valid exactly one cycle after `imem_rd_en`.
- `redirect`  in  1  branch/jump taken; single-cycle pulse.
- `redirect_pc`  in  32  new PC; bits [1:0] are ignored and forced to 0.
- `dec_valid`  out  1  queue head holds an instruction.
- `dec_ready`  in  1  decoder accepts the head this cycle.
- `dec_inst`  out  32  head instruction word.
- `dec_pc_plus4`  out  32  address of the head instruction + 4.

## Operation
- State:
  - `pc`: next fetch address.
  - `inflight`: 1 bit, a read was issued last cycle.
  - `inflight_pc`: address of that read.
  - `drop`: discard the in-flight response.
  - Queue: `QDEPTH` entries of {inst, pc_plus4} plus a count.
- Pop: `dec_valid && dec_ready && !redirect`.
- Issue condition: `!redirect && (count + inflight - pop) < QDEPTH`. On issue: `imem_rd_en`=1, `imem_addr`=`pc`, `pc` ← `pc`+4 (32-bit wrap, no overflow flag), `inflight` ← 1, `inflight_pc` ← `pc`.
- Response: when `inflight && !drop`, push {`imem_rd_data`, `inflight_pc`+4}. Room is guaranteed by the issue condition. Overflow is a design error; assert it in simulation.
- Push and pop in the same cycle: count is unchanged and order is preserved (FIFO).
- Redirect (highest priority):
  - `pc` ← `redirect_pc` & ~3; queue count ← 0.
  - If a read is in flight its response is dropped: `drop` ← `inflight`, `inflight` ← 0.
  - No issue and no pop that cycle; `dec_valid` is forced to 0 in the redirect cycle.
- Redirect during `drop`: `drop` stays set only while a response is still outstanding; a redirect never creates more than one outstanding read.
- Reset values:
  - `pc` = `RESET_PC`; count = 0; `inflight` = 0; `drop` = 0.
  - `imem_rd_en` = 0; `imem_addr` = `RESET_PC`.
  - `dec_valid` = 0; `dec_inst` = 0; `dec_pc_plus4` = 0.
  - `imem_addr` is driven from `pc`, so it reads `RESET_PC` whenever no issue is pending.
- Reset asserted mid-operation: all state clears immediately, and any memory response arriving after release is ignored (`inflight` = 0).

## Timing
- Cycle 0, first edge after reset release: `imem_rd_en`=1, `imem_addr`=`RESET_PC`.
- Cycle 1: data returns and is pushed; `dec_valid`=1 in cycle 2. Fetch-to-decode latency is 2 cycles.
- Steady state with `dec_ready`=1: one issue and one pop per cycle; count settles at 1 and `inflight` at 1.
- Decoder stall (`dec_ready`=0): the queue fills to `QDEPTH`, then issue stops. No instruction is lost or duplicated. After `dec_ready` rises, issue resumes in the same cycle as the first pop.
- Redirect at cycle N:
  - First read from `redirect_pc` is issued at N+1.
  - `dec_valid` is 0 at N+1 and N+2, and rises at N+3 with the target instruction.
- `dec_*` outputs are driven directly from the queue head register; no combinational path from `imem_rd_data` to `dec_*`.

## Structure
- Shared `pipeline_pkg`:
  - `INST_W`=32, `ADDR_W`=32, `RESET_PC_DEFAULT`.
  - Packed typedef `fetch_entry_t` {inst, pc_plus4}, reused by the IF/ID boundary of `instruction_decoder`.
- Sub-module `fetch_queue`: parameterized FIFO of `fetch_entry_t` with push, pop, flush and count. The top level holds the PC, in-flight/drop tracking and issue logic.

## Test plan
- Reset release, memory preloaded with word k = 32'h1000_0000+k, `dec_ready`=1 → `dec_inst` sequence 32'h1000_0000, 32'h1000_0001, … starting 2 cycles after release; `dec_pc_plus4` = 4, 8, 12, …
- Hold `dec_ready`=0 for 10 cycles from the first valid → `imem_rd_en` issues exactly 2 reads then stays 0; on release the words are popped in order with no gaps and no duplicates.
- `redirect`=1 with `redirect_pc`=32'h0000_0103 while a read is in flight and the queue is full → next `imem_addr`=32'h0000_0100; the stale response is dropped; the next `dec_inst` is word 0x40; `dec_valid` is low for exactly 2 cycles after the redirect cycle.
- Back-to-back redirects in consecutive cycles to 0x200 then 0x300 → only the 0x300 stream reaches decode.
- `pc` at 32'hFFFF_FFFC with continuous fetch → next `imem_addr` wraps to 0; `dec_pc_plus4` for that instruction is 0.
- Assert `reset` low for one cycle while the queue holds 2 entries and a read is in flight → `dec_valid` drops immediately; after release the stream restarts at `RESET_PC`; the in-flight response is never delivered.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline types and widths for the fetch front end and the IF/ID boundary.
`default_nettype none

package pipeline_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc_plus4;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// Shift-register prefetch FIFO of fetch entries; the head always sits in slot 0
// so the decoder sees a registered word with no path from memory data.
`default_nettype none

module fetch_queue
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_entry_t                 push_entry,
  input  logic                         pop,
  output fetch_entry_t                 head,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t    entries [DEPTH];
  logic [CW-1:0]   count_next;
  logic [CW-1:0]   wr_idx;

  // A simultaneous pop shifts everything down, so the push lands one slot lower.
  always_comb begin
    wr_idx     = pop ? (count - ONE) : count;
    count_next = count;
    if (push && !pop) begin
      count_next = count + ONE;
    end else if (pop && !push) begin
      count_next = count - ONE;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    fetch_entry_t slot;
    fetch_entry_t shift_in;

    if (i < DEPTH - 1) begin : g_shift
      assign shift_in = entries[i+1];
    end else begin : g_last
      assign shift_in = slot;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        slot <= '0;
      end else if (!flush) begin
        if (push && (wr_idx == CW'(i))) begin
          slot <= push_entry;
        end else if (pop) begin
          slot <= shift_in;
        end
      end
    end

    assign entries[i] = slot;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  assign head  = entries[0];
  assign valid = (count != '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    (push && !pop && !flush) |-> (count < FULL));

  a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
    (pop && !flush) |-> (count != '0));

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC, single outstanding read to a synchronous memory,
// prefetch queue towards decode, and redirect handling.
`default_nettype none

module instruction_fetch_unit
  import pipeline_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int                QDEPTH   = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_rd_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rd_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [INST_W-1:0] dec_inst,
  output logic [ADDR_W-1:0] dec_pc_plus4
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [CW:0] DEPTH_LIMIT = QDEPTH[CW:0];

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic              drop;
  logic              started;

  logic [CW-1:0]     count;
  logic              q_valid;
  fetch_entry_t      head;
  fetch_entry_t      push_entry;
  logic              pop;
  logic              push;
  logic              issue;
  logic [CW:0]       pending;

  // Occupancy after this cycle, counting the read already in flight, decides issue.
  always_comb begin
    pop     = q_valid && dec_ready && !redirect;
    pending = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
    issue   = started && !redirect && (pending < DEPTH_LIMIT);
    push    = inflight && !drop && !redirect;
    push_entry.inst     = imem_rd_data;
    push_entry.pc_plus4 = inflight_pc + ADDR_W'(4);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      inflight_pc <= RESET_PC;
      inflight    <= 1'b0;
      drop        <= 1'b0;
      started     <= 1'b0;
    end else begin
      started <= 1'b1;
      if (redirect) begin
        pc       <= word_align(redirect_pc);
        drop     <= inflight;
        inflight <= 1'b0;
      end else begin
        drop     <= drop && inflight;
        inflight <= issue;
        if (issue) begin
          pc          <= pc + ADDR_W'(4);
          inflight_pc <= pc;
        end
      end
    end
  end

  fetch_queue #(
    .DEPTH(QDEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .valid      (q_valid),
    .count      (count)
  );

  assign imem_rd_en   = issue;
  assign imem_addr    = pc;
  assign dec_valid    = q_valid && !redirect;
  assign dec_inst     = head.inst;
  assign dec_pc_plus4 = head.pc_plus4;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit with a synchronous
// memory whose word at byte address a is 32'h1000_0000 + a[11:2].
`default_nettype none

module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_rd_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd_data = 32'h0;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc_plus4;

  int n_checks = 0;
  int n_errors = 0;
  int reads;

  instruction_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .QDEPTH   (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_rd_en   (imem_rd_en),
    .imem_addr    (imem_addr),
    .imem_rd_data (imem_rd_data),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .dec_valid    (dec_valid),
    .dec_ready    (dec_ready),
    .dec_inst     (dec_inst),
    .dec_pc_plus4 (dec_pc_plus4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_rd_en) imem_rd_data <= 32'h1000_0000 + {22'd0, imem_addr[11:2]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    dec_ready   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rd_en", {31'd0, imem_rd_en}, 32'd0);
    check("rst_addr",  imem_addr, 32'h0000_0000);
    check("rst_valid", {31'd0, dec_valid}, 32'd0);
    check("rst_inst",  dec_inst, 32'h0);
    check("rst_pc4",   dec_pc_plus4, 32'h0);

    // Release with the decoder stalled: two reads, then issue stops
    reset = 1'b1;
    @(negedge clk);
    check("c0_rd_en", {31'd0, imem_rd_en}, 32'd1);
    check("c0_addr",  imem_addr, 32'h0000_0000);
    reads = 1;
    @(negedge clk);
    check("c1_rd_en",  {31'd0, imem_rd_en}, 32'd1);
    check("c1_addr",   imem_addr, 32'h0000_0004);
    check("c1_valid",  {31'd0, dec_valid}, 32'd0);
    reads++;
    @(negedge clk);
    check("c2_valid", {31'd0, dec_valid}, 32'd1);
    check("c2_inst",  dec_inst, 32'h1000_0000);
    check("c2_pc4",   dec_pc_plus4, 32'h0000_0004);
    for (int i = 0; i < 10; i++) begin
      if (imem_rd_en) reads++;
      @(negedge clk);
    end
    check("stall_reads", reads, 32'd2);
    check("stall_inst",  dec_inst, 32'h1000_0000);

    // Release the stall: in-order stream with no gaps
    dec_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check("drain_valid", {31'd0, dec_valid}, 32'd1);
      check("drain_inst",  dec_inst, 32'h1000_0000 + k);
      check("drain_pc4",   dec_pc_plus4, 32'(4 * (k + 1)));
      @(negedge clk);
    end

    // Redirect with a read in flight and queue full (1 entry + 1 in flight)
    dec_ready   = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    #1;
    check("redir_valid_n",  {31'd0, dec_valid}, 32'd0);
    check("redir_no_issue", {31'd0, imem_rd_en}, 32'd0);
    @(negedge clk);
    redirect  = 1'b0;
    dec_ready = 1'b1;
    #1;
    check("redir_n1_rd_en", {31'd0, imem_rd_en}, 32'd1);
    check("redir_n1_addr",  imem_addr, 32'h0000_0100);
    check("redir_n1_valid", {31'd0, dec_valid}, 32'd0);
    @(negedge clk);
    check("redir_n2_valid", {31'd0, dec_valid}, 32'd0);
    check("redir_n2_addr",  imem_addr, 32'h0000_0104);
    @(negedge clk);
    check("redir_n3_valid", {31'd0, dec_valid}, 32'd1);
    check("redir_n3_inst",  dec_inst, 32'h1000_0040);
    check("redir_n3_pc4",   dec_pc_plus4, 32'h0000_0104);
    @(negedge clk);
    check("redir_n4_inst",  dec_inst, 32'h1000_0041);

    // Back-to-back redirects: only the 0x300 stream survives
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    #1;
    check("b2b_m0_valid", {31'd0, dec_valid}, 32'd0);
    @(negedge clk);
    redirect_pc = 32'h0000_0300;
    #1;
    check("b2b_m1_rd_en", {31'd0, imem_rd_en}, 32'd0);
    check("b2b_m1_valid", {31'd0, dec_valid}, 32'd0);
    @(negedge clk);
    redirect = 1'b0;
    #1;
    check("b2b_m2_addr",  imem_addr, 32'h0000_0300);
    check("b2b_m2_valid", {31'd0, dec_valid}, 32'd0);
    @(negedge clk);
    check("b2b_m3_valid", {31'd0, dec_valid}, 32'd0);
    @(negedge clk);
    check("b2b_m4_valid", {31'd0, dec_valid}, 32'd1);
    check("b2b_m4_inst",  dec_inst, 32'h1000_00C0);
    check("b2b_m4_pc4",   dec_pc_plus4, 32'h0000_0304);
    @(negedge clk);
    check("b2b_m5_inst",  dec_inst, 32'h1000_00C1);

    // PC wrap at the top of the address space
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap_rd_en",  {31'd0, imem_rd_en}, 32'd1);
    check("wrap_addr_0", imem_addr, 32'h0000_0000);
    @(negedge clk);
    check("wrap_inst",   dec_inst, 32'h1000_03FF);
    check("wrap_pc4",    dec_pc_plus4, 32'h0000_0000);
    @(negedge clk);
    check("wrap_inst_next", dec_inst, 32'h1000_0000);
    check("wrap_pc4_next",  dec_pc_plus4, 32'h0000_0004);

    // Reset mid-stream with a read in flight
    reset = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, dec_valid}, 32'd0);
    check("mid_rst_rd_en", {31'd0, imem_rd_en}, 32'd0);
    check("mid_rst_addr",  imem_addr, 32'h0000_0000);
    check("mid_rst_inst",  dec_inst, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rel_rd_en", {31'd0, imem_rd_en}, 32'd0);
    @(negedge clk);
    check("rel_c0_rd_en", {31'd0, imem_rd_en}, 32'd1);
    check("rel_c0_addr",  imem_addr, 32'h0000_0000);
    check("rel_c0_valid", {31'd0, dec_valid}, 32'd0);
    @(negedge clk);
    check("rel_c1_valid", {31'd0, dec_valid}, 32'd0);
    @(negedge clk);
    check("rel_c2_valid", {31'd0, dec_valid}, 32'd1);
    check("rel_c2_inst",  dec_inst, 32'h1000_0000);
    check("rel_c2_pc4",   dec_pc_plus4, 32'h0000_0004);
    @(negedge clk);
    check("rel_c3_inst",  dec_inst, 32'h1000_0001);
    check("rel_c3_pc4",   dec_pc_plus4, 32'h0000_0008);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
